// File: rtl/poly_sampler_engine.sv
// Polyphonic sample-playback engine: per frame, reads one word per active voice, mixes and saturates.
// Optional per-voice attenuation (arithmetic right shift) is enabled with `define SAMPLER_VOLUME_EN.
module poly_sampler_engine #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 16
) (
    input  logic                           clk100,
    input  logic                           reset,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES-1:0]          trigger,
    input  logic [NUM_VOICES-1:0]          loop_en,
    input  logic [NUM_VOICES*ADDR_W-1:0]   start_addr,
    input  logic [NUM_VOICES*ADDR_W-1:0]   length,
    output logic                           rd_req,
    output logic [ADDR_W-1:0]              rd_addr,
    input  logic                           rd_ack,
    input  logic signed [DATA_W-1:0]       rd_data,
    output logic signed [DATA_W-1:0]       audio_out,
    output logic                           audio_valid,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic                           overrun
`ifdef SAMPLER_VOLUME_EN
    ,
    input  logic [NUM_VOICES*4-1:0]        atten
`endif
);

    localparam int ACC_W = DATA_W + $clog2(NUM_VOICES);
    localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VI_W-1:0] LAST_V = VI_W'(NUM_VOICES - 1);
    localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SCAN, REQ, ACC, OUT} state_t;

    state_t                   state, state_nx;
    logic [VI_W-1:0]          v_idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [DATA_W-1:0] sample_q;
    logic signed [DATA_W-1:0] sat;
    logic                     retrig;
    logic [ADDR_W-1:0]        ptr     [NUM_VOICES];
    logic [ADDR_W-1:0]        start_v [NUM_VOICES];
    logic [ADDR_W-1:0]        end_v   [NUM_VOICES];
    logic [NUM_VOICES-1:0]    trig_ok;
    logic                     cur_active, cur_trig, cur_last;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        assign start_v[g] = start_addr[g*ADDR_W +: ADDR_W];
        assign end_v[g]   = start_addr[g*ADDR_W +: ADDR_W] + length[g*ADDR_W +: ADDR_W] - ADDR_W'(1);
        assign trig_ok[g] = trigger[g] && (length[g*ADDR_W +: ADDR_W] != '0);
    end

    assign cur_active = voice_active[v_idx];
    assign cur_trig   = trig_ok[v_idx];
    assign cur_last   = (v_idx == LAST_V);
    // Decoded straight from the state flop so an async reset drops the request at once.
    assign rd_req     = (state == REQ);

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (sample_tick) state_nx = SCAN;
            SCAN: begin
                if (cur_active)    state_nx = REQ;
                else if (cur_last) state_nx = OUT;
            end
            REQ:  if (rd_ack) state_nx = ACC;
            ACC:  state_nx = cur_last ? OUT : SCAN;
            OUT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sample_ext = ACC_W'(sample_q);
`ifdef SAMPLER_VOLUME_EN
        sample_ext = sample_ext >>> atten[4*v_idx +: 4];
`endif
    end

    always_comb begin
        if (acc > ACC_W'(D_MAX))      sat = D_MAX;
        else if (acc < ACC_W'(D_MIN)) sat = D_MIN;
        else                          sat = acc[DATA_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            v_idx       <= '0;
            acc         <= '0;
            sample_q    <= '0;
            rd_addr     <= '0;
            retrig      <= 1'b0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            if (sample_tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        v_idx <= '0;
                        acc   <= '0;
                    end
                end
                SCAN: begin
                    if (cur_active) begin
                        rd_addr <= ptr[v_idx];
                        retrig  <= cur_trig;
                    end else if (!cur_last) begin
                        v_idx <= v_idx + 1'b1;
                    end
                end
                REQ: begin
                    if (cur_trig) retrig   <= 1'b1;
                    if (rd_ack)   sample_q <= rd_data;
                end
                ACC: begin
                    acc    <= acc + sample_ext;
                    retrig <= 1'b0;
                    if (!cur_last) v_idx <= v_idx + 1'b1;
                end
                OUT: begin
                    audio_out   <= sat;
                    audio_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A trigger always wins over the advance; a retrigger seen during this voice's read skips the +1.
    // NOTE: the pointer array is a handful of flops, so it is reset like any other state.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) ptr[i] <= '0;
            voice_active <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (trig_ok[i]) begin
                    ptr[i]          <= start_v[i];
                    voice_active[i] <= 1'b1;
                end else if (state == ACC && v_idx == VI_W'(i) && !retrig) begin
                    if (ptr[i] == end_v[i]) begin
                        if (loop_en[i]) ptr[i]          <= start_v[i];
                        else            voice_active[i] <= 1'b0;
                    end else begin
                        ptr[i] <= ptr[i] + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule
